// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Purpose  : Writeback-stage general-purpose register file. It has one write
//            port fed by MEM/WB and two combinational read ports for ID.
//            After every reset a clear engine zeroes r1..r(NREGS-1), one
//            register per cycle. init_busy is held high while it runs.
//            r0 is hardwired to zero. A same-cycle write is forwarded to a
//            reader of the same register.
// Ports    : clk                   rising-edge clock
//            rst                   synchronous reset, active-low
//            we / waddr / wdata    write port
//            re1 / raddr1 / rdata1 read port 1 (combinational)
//            re2 / raddr2 / rdata2 read port 2 (combinational)
//            init_busy             high while the clear engine runs
// Revision : 1.0  initial release
// ============================================================================
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic              init_busy
);

    localparam int NREGS = 1 << ADDR_W;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NREGS - 1);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic              busy_q,  busy_d;

    // Entry 0 is the constant zero register. Every other entry is a flop.
    logic [DATA_W-1:0] w_regs [NREGS];

    // ------------------------------------------------------------------
    // Control: clear-engine sequencing
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == c_LAST) begin
                state_d = S_RUN;
                busy_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_INIT;
            cnt_q   <= ADDR_W'(1);
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign init_busy = busy_q;

    // ------------------------------------------------------------------
    // Storage. The array is deliberately left untouched while reset is
    // asserted. Clearing happens only in INIT, and external writes are
    // accepted only in RUN.
    // ------------------------------------------------------------------
    assign w_regs[0] = '0;

    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
        logic [DATA_W-1:0] reg_q;
        logic              w_clr;
        logic              w_wr;

        assign w_clr = (state_q == S_INIT) && (cnt_q == ADDR_W'(gi));
        assign w_wr  = (state_q == S_RUN) && we && (waddr == ADDR_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                if (w_clr) begin
                    reg_q <= '0;
                end else if (w_wr) begin
                    reg_q <= wdata;
                end
            end
        end

        assign w_regs[gi] = reg_q;
    end

    // ------------------------------------------------------------------
    // Read ports. Both ports use the same priority chain. The bypass
    // compares against a non-zero index only, so r0 can never be forwarded.
    // ------------------------------------------------------------------
    logic w_rd_block;
    assign w_rd_block = !rst || (state_q == S_INIT);

    always_comb begin
        rdata1 = '0;
        if (!w_rd_block && re1 && (raddr1 != '0)) begin
            if (we && (waddr == raddr1)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = w_regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (!w_rd_block && re2 && (raddr2 != '0)) begin
            if (we && (waddr == raddr2)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = w_regs[raddr2];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Purpose  : Self-checking bench for regfile. Contains a behavioural model,
//            a per-cycle compare process, directed scenarios and a random
//            phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              init_busy;

    int checks;
    int errors;
    bit cmp_en;

    regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .re1       (re1),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .re2       (re2),
        .raddr2    (raddr2),
        .rdata2    (rdata2),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model. The clear sequence is modelled only as a countdown
    // of remaining clear edges. Once the countdown reaches zero, every
    // register is zero.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [NREGS];
    int                init_left = NREGS - 1;

    always @(posedge clk) begin
        if (!rst) begin
            init_left = NREGS - 1;
        end else if (init_left > 0) begin
            init_left = init_left - 1;
            if (init_left == 0) begin
                for (int i = 0; i < NREGS; i++) mem[i] = '0;
            end
        end else if (we && waddr != 0) begin
            mem[waddr] = wdata;
        end
    end

    function automatic logic [DATA_W-1:0] exp_rd(input logic re,
                                                 input logic [ADDR_W-1:0] a);
        if (!rst || init_left > 0) return '0;
        if (!re)                   return '0;
        if (a == 0)                return '0;
        if (we && waddr == a)      return wdata;
        return mem[a];
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {31'b0, init_busy}, {31'b0, (init_left > 0)});
            chk("model_rdata1", rdata1, exp_rd(re1, raddr1));
            chk("model_rdata2", rdata2, exp_rd(re2, raddr2));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd4;

        // Reset held for 3 cycles.
        step();
        cmp_en = 1'b1;
        step();
        step();
        chk("reset_busy", {31'b0, init_busy}, 32'd1);
        chk("reset_rdata1", rdata1, 32'h0);

        // Release reset. init_busy stays high for exactly 31 edges.
        rst = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (init_busy && n < 100);
        chk("clear_edges", n, 32'd31);

        // Every register reads zero on both ports.
        for (int i = 0; i < NREGS; i++) begin
            raddr1 = ADDR_W'(i);
            raddr2 = ADDR_W'(NREGS - 1 - i);
            #1;
            chk("cleared_p1", rdata1, 32'h0);
            chk("cleared_p2", rdata2, 32'h0);
            step();
        end

        // Basic write, then read on both ports.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
        #1;
        chk("wr_rd_p1", rdata1, 32'hDEADBEEF);
        chk("wr_rd_p2", rdata2, 32'hDEADBEEF);

        // Bypass in the same cycle, then readback from the array.
        step();
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; raddr2 = 5'd7;
        #1;
        chk("bypass_p2", rdata2, 32'h12345678);
        step();
        we = 1'b0;
        #1;
        chk("after_bypass_p2", rdata2, 32'h12345678);

        // r0 cannot be written and is never bypassed.
        step();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
        #1;
        chk("r0_bypass", rdata1, 32'h0);
        step();
        we = 1'b0;
        #1;
        chk("r0_stored", rdata1, 32'h0);

        // Read-enable gating.
        step();
        we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
        step();
        we = 1'b0; re1 = 1'b0; raddr1 = 5'd9;
        #1;
        chk("re_gated", rdata1, 32'h0);
        re1 = 1'b1;
        #1;
        chk("re_open", rdata1, 32'hA5A5A5A5);

        // Reset mid-operation while r5 holds DEADBEEF.
        step();
        raddr1 = 5'd5;
        #1;
        chk("pre_reset_r5", rdata1, 32'hDEADBEEF);
        rst = 1'b0;
        #1;
        chk("in_reset_rd", rdata1, 32'h0);
        step();
        rst = 1'b1;
        chk("midreset_busy", {31'b0, init_busy}, 32'd1);
        n = 0;
        do begin
            if (n == 5) begin
                we = 1'b1; waddr = 5'd5; wdata = 32'h11111111;
                #1;
                chk("init_wr_dropped", rdata1, 32'h0);
            end else begin
                we = 1'b0;
            end
            step();
            n++;
        end while (init_busy && n < 100);
        we = 1'b0;
        chk("reclear_edges", n, 32'd31);
        #1;
        chk("r5_recleared", rdata1, 32'h0);

        // Random phase with rare resets and frequent address collisions.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst    = ($urandom_range(0, 299) != 0);
            we     = $urandom_range(0, 1) == 1;
            waddr  = ADDR_W'($urandom_range(0, NREGS - 1));
            wdata  = $urandom;
            re1    = $urandom_range(0, 7) != 0;
            re2    = $urandom_range(0, 7) != 0;
            raddr1 = ($urandom_range(0, 3) == 0) ? waddr
                                                 : ADDR_W'($urandom_range(0, NREGS - 1));
            raddr2 = ($urandom_range(0, 3) == 0) ? raddr1
                                                 : ADDR_W'($urandom_range(0, NREGS - 1));
        end
        rst = 1'b1; we = 1'b0;
        for (int c = 0; c < 40; c++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
